// File: rtl/glb_write_arbiter.sv
// glb_write_arbiter: round-robin arbiter that shares one valid/ready GLB write
// channel among NUM_SRC streaming sources. It arms on the falling edge of
// flush and grants bursts of up to BURST_LEN accepted beats per source. It
// raises all_done once every source has reported done.
// Optional: define GLB_ARB_STATS_EN to add the beat_total accepted-beat counter.
module glb_write_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 8,
  localparam int ID_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int CNT_W    = $clog2(BURST_LEN + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC-1:0]        src_done,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ID_W-1:0]           out_src_id,
  output logic                      all_done
`ifdef GLB_ARB_STATS_EN
  ,
  output logic [31:0]               beat_total
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ARB, S_GRANT, S_DONE} state_t;

  state_t               state_q, state_d;
  logic                 flush_q;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]      grant_q, grant_d;
  logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
  logic [NUM_SRC-1:0]   done_seen_q, done_seen_d;

  logic                 flush_fall, flush_rise;
  logic [NUM_SRC-1:0]   eligible;
  logic                 pick_found;
  logic [ID_W-1:0]      pick_idx;
  logic [DATA_W-1:0]    g_data;
  logic                 g_valid, g_done;
  logic                 accept, last_beat;
  logic [ID_W-1:0]      rr_next;

  assign flush_fall = flush_q & ~flush;
  assign flush_rise = flush & ~flush_q;

  // A source asserting done this cycle is excluded even if it is also valid.
  assign eligible = src_valid & ~done_seen_q & ~src_done;

  // Round-robin pick: first eligible source starting at rr_ptr, wrapping.
  always_comb begin
    int idx;
    idx        = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      if (!pick_found && eligible[idx]) begin
        pick_found = 1'b1;
        pick_idx   = ID_W'(idx);
      end
    end
  end

  // Mux out the granted source's data, valid and done.
  always_comb begin
    g_data  = '0;
    g_valid = 1'b0;
    g_done  = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q == ID_W'(i)) begin
        g_data  = src_data[i*DATA_W +: DATA_W];
        g_valid = src_valid[i];
        g_done  = src_done[i];
      end
    end
  end

  assign accept    = (state_q == S_GRANT) && g_valid && out_ready;
  assign last_beat = accept && (beat_cnt_q == CNT_W'(BURST_LEN - 1));
  assign rr_next   = (grant_q == ID_W'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;

  // State and bookkeeping registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      flush_q     <= 1'b0;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      beat_cnt_q  <= '0;
      done_seen_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_q     <= flush;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      beat_cnt_q  <= beat_cnt_d;
      done_seen_q <= done_seen_d;
    end
  end

  // Next-state logic: arming, arbitration, burst release and completion.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    beat_cnt_d  = beat_cnt_q;
    done_seen_d = done_seen_q;
    if (state_q != S_IDLE) done_seen_d = done_seen_q | src_done;
    case (state_q)
      S_IDLE: begin
        if (flush_fall) begin
          state_d     = S_ARB;
          done_seen_d = '0;
        end
      end
      S_ARB: begin
        if (flush_rise) begin
          state_d = S_IDLE;
        end else if (pick_found) begin
          grant_d    = pick_idx;
          beat_cnt_d = '0;
          state_d    = S_GRANT;
        end else if (&done_seen_q) begin
          state_d = S_DONE;
        end
      end
      S_GRANT: begin
        // The beat on a release cycle still counts; the handshake is combinational.
        if (accept) beat_cnt_d = beat_cnt_q + 1'b1;
        if (flush_rise) begin
          state_d = S_IDLE;
        end else if (last_beat || !g_valid || g_done) begin
          state_d  = S_ARB;
          rr_ptr_d = rr_next;
        end
      end
      S_DONE: begin
        if (flush_fall) begin
          state_d     = S_ARB;
          done_seen_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: zero-latency passthrough while granted, all_done in DONE, else zero.
  always_comb begin
    out_data   = '0;
    out_valid  = 1'b0;
    src_ready  = '0;
    out_src_id = '0;
    all_done   = 1'b0;
    case (state_q)
      S_GRANT: begin
        out_data   = g_data;
        out_valid  = g_valid;
        out_src_id = grant_q;
        for (int i = 0; i < NUM_SRC; i++)
          src_ready[i] = (grant_q == ID_W'(i)) & out_ready;
      end
      S_DONE:  all_done = 1'b1;
      default: ;
    endcase
  end

`ifdef GLB_ARB_STATS_EN
  logic [31:0] beat_total_q;

  // Saturating count of accepted beats since the last arm.
  always_ff @(posedge clk) begin
    if (rst)                             beat_total_q <= '0;
    else if (flush_fall)                 beat_total_q <= '0;
    else if (accept && ~&beat_total_q)   beat_total_q <= beat_total_q + 32'd1;
  end

  assign beat_total = beat_total_q;
`endif

endmodule

// File: tb/tb_glb_write_arbiter.sv
// tb_glb_write_arbiter: directed scoreboard bench for glb_write_arbiter.
// Sources emit {src_id[3:0], seq[11:0]} words; the expected beat stream is
// queued when stimulus is issued and a negedge monitor pops and compares.
module tb_glb_write_arbiter;
  localparam int NS = 4;
  localparam int DW = 16;
  localparam int BL = 8;

  logic             clk = 1'b0;
  logic             rst, flush, out_ready;
  logic [NS*DW-1:0] src_data;
  logic [NS-1:0]    src_valid, src_ready, src_done;
  logic [DW-1:0]    out_data;
  logic             out_valid;
  logic [1:0]       out_src_id;
  logic             all_done;
`ifdef GLB_ARB_STATS_EN
  logic [31:0]      beat_total;
`endif

  int sent [NS];
  int tgt  [NS];
  int vecs = 0, errs = 0;
  int acc_cnt = 0, cyc = 0, first_acc = -1, last_acc = -1;
  logic [17:0] exp_q [$];

  always #5 clk = ~clk;

  glb_write_arbiter #(.NUM_SRC(NS), .DATA_W(DW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .src_done(src_done),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_src_id(out_src_id), .all_done(all_done)
`ifdef GLB_ARB_STATS_EN
    , .beat_total(beat_total)
`endif
  );

  // Source model: valid while it still has beats to send.
  always_comb begin
    for (int i = 0; i < NS; i++) begin
      src_valid[i]            = (sent[i] != tgt[i]);
      src_data[i*DW +: DW]    = {4'(i), 12'(sent[i])};
    end
  end

  // Source side: advance a source's sequence on each handshake.
  initial begin
    logic [NS-1:0] f;
    for (int i = 0; i < NS; i++) sent[i] = 0;
    forever begin
      @(negedge clk);
      f = src_valid & src_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++) if (f[i]) sent[i]++;
    end
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: compares every accepted beat with the head of the queue.
  initial forever begin
    logic [3:0] er;
    @(negedge clk);
    if (!rst && out_valid) begin
      er = out_ready ? (4'b0001 << out_src_id) : 4'b0000;
      chk("ready_mirror", 64'(src_ready), 64'(er));
    end
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL unexpected_beat: got %0h expected none", {out_src_id, out_data});
      end else begin
        chk("beat", 64'({out_src_id, out_data}), 64'(exp_q.pop_front()));
      end
      acc_cnt++;
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_beats(input int s, input int base, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({2'(s), 4'(s), 12'(base + k)});
  endtask

  task automatic wait_acc(input int n, input string nm, output int k);
    k = 0;
    while (acc_cnt < n && k < 400) begin
      @(posedge clk);
      #2;
      k++;
    end
    chk(nm, 64'(acc_cnt), 64'(n));
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_valid"}, 64'(out_valid), 64'(0));
    chk({nm, "_ready"}, 64'(src_ready), 64'(0));
    chk({nm, "_data"},  64'(out_data),  64'(0));
    chk({nm, "_id"},    64'(out_src_id), 64'(0));
    chk({nm, "_done"},  64'(all_done),  64'(0));
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk_idle("reset");
    tick();
    rst = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    int b [NS];
    int a, k;
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1; src_done = '0;
    for (int i = 0; i < NS; i++) tgt[i] = 0;
    tick();
    reset_dut();

    // Single source: 20 beats in bursts 8,8,4 with one bubble each re-arbitration.
    a = acc_cnt;
    tgt[0] = sent[0] + 20;
    push_beats(0, sent[0], 20);
    pulse_flush();
    wait_acc(a + 20, "single_20_beats", k);
    chk("single_cycle_count", 64'(k), 64'(24));
    repeat (3) tick();
    src_done = 4'b0001;
    repeat (3) tick();
    @(negedge clk);
    chk("all_done_one", 64'(all_done), 64'(0));
    src_done = 4'b0111;
    repeat (3) tick();
    @(negedge clk);
    chk("all_done_three", 64'(all_done), 64'(0));
    src_done = 4'b1111;
    tick();
    tick();
    @(negedge clk);
    chk("all_done_four", 64'(all_done), 64'(1));
    chk("done_no_valid", 64'(out_valid), 64'(0));
    src_done = '0;

    // Round robin: all four valid, two 8-beat grants each, order 0,1,2,3,0,...
    reset_dut();
    a = acc_cnt;
    for (int i = 0; i < NS; i++) begin b[i] = sent[i]; tgt[i] = sent[i] + 16; end
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NS; i++) push_beats(i, b[i] + 8 * r, 8);
    pulse_flush();
    wait_acc(a + 64, "rr_64_beats", k);

    // Backpressure: out_ready alternates; one grant of 8 accepted beats.
    reset_dut();
    a = acc_cnt;
    tgt[1] = sent[1] + 8;
    push_beats(1, sent[1], 8);
    first_acc = -1;
    pulse_flush();
    k = 0;
    while (acc_cnt < a + 8 && k < 60) begin
      tick();
      out_ready = ~out_ready;
      k++;
    end
    out_ready = 1'b1;
    chk("bp_beats", 64'(acc_cnt), 64'(a + 8));
    chk("bp_span", 64'(last_acc - first_acc), 64'(14));

    // Stall and done: src1 done (never granted), src2 stalls after 3 beats.
    reset_dut();
    a = acc_cnt;
    for (int i = 0; i < NS; i++) b[i] = sent[i];
    src_done = 4'b0010;
    tgt[0] = b[0] + 8; tgt[1] = b[1] + 8; tgt[2] = b[2] + 3; tgt[3] = b[3] + 8;
    push_beats(0, b[0], 8);
    push_beats(2, b[2], 3);
    push_beats(3, b[3], 8);
    pulse_flush();
    wait_acc(a + 19, "stall_first_pass", k);
    repeat (3) tick();
    tgt[2] = b[2] + 5;
    push_beats(2, b[2] + 3, 2);
    wait_acc(a + 21, "stall_resume", k);
    repeat (3) tick();
    src_done = 4'b1111;
    tick();
    tick();
    @(negedge clk);
    chk("stall_all_done", 64'(all_done), 64'(1));
    tick();
    tgt[1] = sent[1];
    src_done = '0;

    // Reset at beat 5, rearm from src 0, then flush rise mid-grant.
    reset_dut();
    a = acc_cnt;
    tgt[0] = sent[0] + 8;
    push_beats(0, sent[0], 5);
    pulse_flush();
    wait_acc(a + 5, "pre_reset_beats", k);
    rst = 1'b1;
    tick();
    @(negedge clk);
    chk_idle("rst_mid");
    tick();
    rst = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("idle_after_rst", 64'(out_valid), 64'(0));
    tick();
    a = acc_cnt;
    tgt[0] = sent[0] + 3;
    push_beats(0, sent[0], 3);
    tgt[1] = sent[1] + 4;
    push_beats(1, sent[1], 4);
    tgt[3] = sent[3] + 8;
    push_beats(3, sent[3], 8);
    pulse_flush();
    wait_acc(a + 10, "rearm_beats", k);
    flush = 1'b1;
    tick();
    @(negedge clk);
    chk("flush_rise_valid", 64'(out_valid), 64'(0));
    chk("flush_rise_id", 64'(out_src_id), 64'(0));
    tick();
    flush = 1'b0;
    wait_acc(a + 15, "post_flush_beats", k);

    // Four sources x 10 beats; bursts 8 then 2 per source.
    reset_dut();
    a = acc_cnt;
    for (int i = 0; i < NS; i++) begin b[i] = sent[i]; tgt[i] = sent[i] + 10; end
    for (int i = 0; i < NS; i++) push_beats(i, b[i], 8);
    for (int i = 0; i < NS; i++) push_beats(i, b[i] + 8, 2);
    pulse_flush();
    wait_acc(a + 40, "stats_40_beats", k);
`ifdef GLB_ARB_STATS_EN
    tick();
    @(negedge clk);
    chk("beat_total_40", 64'(beat_total), 64'(40));
    tick();
    pulse_flush();
    tick();
    @(negedge clk);
    chk("beat_total_clear", 64'(beat_total), 64'(0));
`endif
    repeat (2) tick();
    chk("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
